// File: rtl/spm_responder.sv
// spm_responder: single-port word-addressed scratchpad, responder end of the simple bus.
// Samples a request in IDLE, waits WAIT_CYCLES, then pulses rdy_ low for one cycle.
// Optional build macro: SPM_BYTE_WE_EN adds active-low per-byte write enables (be_).
module spm_responder #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                as_,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef SPM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] be_,
`endif
    output logic [DATA_W-1:0]   rd_data,
    output logic                rdy_,
    output logic                busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Counter preload; only meaningful when WAIT_CYCLES is non-zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;

`ifdef SPM_BYTE_WE_EN
    localparam int NBYTES = DATA_W / 8;
    logic [NBYTES-1:0]     be_q, be_d;
`endif

    // Upper address bits alias onto the RAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2];

    // Next-state and output decode for the IDLE -> WAIT -> RESP handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        rdy_d     = 1'b1;
        busy_d    = busy_q;
`ifdef SPM_BYTE_WE_EN
        be_d      = be_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (!as_) begin
                    rw_d    = rw;
                    addr_d  = addr[DEPTH_LOG2-1:0];
                    wdata_d = wr_data;
`ifdef SPM_BYTE_WE_EN
                    be_d    = be_;
`endif
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rdy_d   = 1'b0;
                state_d = IDLE;
                if (rw_q) begin
                    rd_data_d = mem[addr_q];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef SPM_BYTE_WE_EN
            be_q      <= '1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
`ifdef SPM_BYTE_WE_EN
            be_q      <= be_d;
`endif
        end
    end

    // RAM write commits at the end of RESP; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (state_q == RESP && !rw_q) begin
`ifdef SPM_BYTE_WE_EN
            for (int i = 0; i < NBYTES; i++) begin
                if (!be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
`else
            mem[addr_q] <= wdata_q;
`endif
        end
    end

    assign rd_data = rd_data_q;
    assign rdy_    = rdy_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spm_responder.sv
// tb_spm_responder: scoreboard bench for spm_responder.
// Three instances share clock and reset, built with WAIT_CYCLES = 0, 1 and 4.
module tb_spm_responder;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          as_v    [3];
    logic          rw_v    [3];
    logic [AW-1:0] addr_v  [3];
    logic [DW-1:0] wr_v    [3];
    logic [DW-1:0] rd_v    [3];
    logic          rdy_v   [3];
    logic          busy_v  [3];
`ifdef SPM_BYTE_WE_EN
    logic [BW-1:0] be_v    [3];
`endif

    int            wc [3] = '{0, 1, 4};
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [DW-1:0] model   [3][1024];
    logic [DW-1:0] last_rd [3];
    logic [DW-1:0] exp_q   [$];

    spm_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .as_(as_v[0]), .rw(rw_v[0]), .addr(addr_v[0]), .wr_data(wr_v[0]),
`ifdef SPM_BYTE_WE_EN
        .be_(be_v[0]),
`endif
        .rd_data(rd_v[0]), .rdy_(rdy_v[0]), .busy(busy_v[0]));

    spm_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .as_(as_v[1]), .rw(rw_v[1]), .addr(addr_v[1]), .wr_data(wr_v[1]),
`ifdef SPM_BYTE_WE_EN
        .be_(be_v[1]),
`endif
        .rd_data(rd_v[1]), .rdy_(rdy_v[1]), .busy(busy_v[1]));

    spm_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(10), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .as_(as_v[2]), .rw(rw_v[2]), .addr(addr_v[2]), .wr_data(wr_v[2]),
`ifdef SPM_BYTE_WE_EN
        .be_(be_v[2]),
`endif
        .rd_data(rd_v[2]), .rdy_(rdy_v[2]), .busy(busy_v[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One bus transaction: push expectation, wait for rdy_, check latency and data.
    task automatic txn(input int d, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be, input string name);
        int            n;
        logic [DW-1:0] e;
        @(negedge clk);
        as_v[d]   = 1'b0;
        rw_v[d]   = r;
        addr_v[d] = a;
        wr_v[d]   = wd;
`ifdef SPM_BYTE_WE_EN
        be_v[d]   = be;
`endif
        if (r) begin
            exp_q.push_back(model[d][a[9:0]]);
        end else begin
            for (int i = 0; i < BW; i++) begin
`ifdef SPM_BYTE_WE_EN
                if (!be[i]) model[d][a[9:0]][8*i +: 8] = wd[8*i +: 8];
`else
                if (be[i] == 1'b0) model[d][a[9:0]][8*i +: 8] = wd[8*i +: 8];
`endif
            end
        end
        @(posedge clk);
        #1;
        as_v[d] = 1'b1;
        checks++;
        if (busy_v[d] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s busy after sample: got %b expected 1", name, busy_v[d]);
        end
        n = 0;
        while (rdy_v[d] !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== wc[d] + 1) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d cycles expected %0d", name, n, wc[d] + 1);
            if (n >= 40) begin
                if (r && exp_q.size() > 0) void'(exp_q.pop_front());
                return;
            end
        end
        checks++;
        if (busy_v[d] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s busy during rdy_: got %b expected 1", name, busy_v[d]);
        end
        if (r) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s scoreboard: got empty queue expected one entry", name);
            end else begin
                e = exp_q.pop_front();
                if (rd_v[d] !== e) begin
                    errors++;
                    $display("[TB] FAIL %s read data: got %h expected %h", name, rd_v[d], e);
                end
                last_rd[d] = e;
            end
        end else begin
            checks++;
            if (rd_v[d] !== last_rd[d]) begin
                errors++;
                $display("[TB] FAIL %s rd_data after write: got %h expected %h", name, rd_v[d], last_rd[d]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (rdy_v[d] !== 1'b1 || busy_v[d] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s release: got rdy_=%b busy=%b expected rdy_=1 busy=0", name, rdy_v[d], busy_v[d]);
        end
    endtask

    // Hold reset, release, then idle and confirm quiet outputs on every instance.
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rdy_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || rd_v[d] !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_idle dut%0d: got rdy_=%b busy=%b rd=%h expected 1 0 0",
                             d, rdy_v[d], busy_v[d], rd_v[d]);
                end
            end
        end
    endtask

    // Write then read the same word with one wait state.
    task automatic test_write_read();
        txn(1, 1'b0, 30'h10, 32'hDEADBEEF, '0, "wr_10");
        txn(1, 1'b1, 30'h10, 32'h0, '0, "rd_10");
        checks++;
        if (rd_v[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL rd_10_const: got %h expected deadbeef", rd_v[1]);
        end
    endtask

    // Continuous as_ low with zero wait states: one response every two cycles.
    task automatic test_back_to_back();
        int            n;
        int            prev;
        logic [DW-1:0] e;
        for (int i = 0; i < 4; i++) begin
            txn(0, 1'b0, AW'(i), DW'(32'h11 * i), '0, "b2b_preload");
        end
        @(negedge clk);
        as_v[0]   = 1'b0;
        rw_v[0]   = 1'b1;
        addr_v[0] = '0;
        exp_q.push_back(model[0][0]);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (rdy_v[0] !== 1'b0 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("[TB] FAIL b2b timeout beat %0d: got no rdy_ expected pulse", i);
                break;
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev !== 2) begin
                    errors++;
                    $display("[TB] FAIL b2b spacing beat %0d: got %0d expected 2", i, cyc - prev);
                end
            end
            prev = cyc;
            e = exp_q.pop_front();
            if (rd_v[0] !== e || rd_v[0] !== DW'(32'h11 * i)) begin
                errors++;
                $display("[TB] FAIL b2b data beat %0d: got %h expected %h", i, rd_v[0], e);
            end
            last_rd[0] = e;
            if (i < 3) begin
                addr_v[0] = AW'(i + 1);
                exp_q.push_back(model[0][i + 1]);
            end else begin
                as_v[0] = 1'b1;
            end
            @(posedge clk);
            #1;
            checks++;
            if (rdy_v[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b pulse width beat %0d: got rdy_=%b expected 1", i, rdy_v[0]);
            end
        end
        exp_q.delete();
    endtask

    // Upper address bits are ignored; top word and word 0 stay distinct.
    task automatic test_alias();
        txn(1, 1'b0, 30'h400, 32'h12345678, '0, "alias_wr");
        txn(1, 1'b1, 30'h000, 32'h0, '0, "alias_rd");
        checks++;
        if (rd_v[1] !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL alias_const: got %h expected 12345678", rd_v[1]);
        end
        txn(1, 1'b0, 30'h3FFFFFFF, 32'h0BADF00D, '0, "top_wr");
        txn(1, 1'b1, 30'h3FF, 32'h0, '0, "top_rd");
        checks++;
        if (rd_v[1] !== 32'h0BADF00D) begin
            errors++;
            $display("[TB] FAIL top_const: got %h expected 0badf00d", rd_v[1]);
        end
        txn(1, 1'b1, 30'h000, 32'h0, '0, "word0_rd");
    endtask

    // Reset during WAIT drops the pending write and suppresses its rdy_.
    task automatic test_reset_mid_wait();
        txn(2, 1'b0, 30'h5, 32'h1, '0, "mw_preload");
        @(negedge clk);
        as_v[2]   = 1'b0;
        rw_v[2]   = 1'b0;
        addr_v[2] = 30'h5;
        wr_v[2]   = 32'hCAFE;
`ifdef SPM_BYTE_WE_EN
        be_v[2]   = '0;
`endif
        @(posedge clk);
        #1;
        as_v[2] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rdy_v[2] !== 1'b1 || busy_v[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_wait reset: got rdy_=%b busy=%b expected 1 0", rdy_v[2], busy_v[2]);
        end
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            checks++;
            if (rdy_v[2] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mid_wait stray rdy_: got %b expected 1", rdy_v[2]);
            end
        end
        txn(2, 1'b1, 30'h5, 32'h0, '0, "mw_rd");
        checks++;
        if (rd_v[2] !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mw_const: got %h expected 00000001", rd_v[2]);
        end
    endtask

`ifdef SPM_BYTE_WE_EN
    // Byte-enabled write merges only the enabled lanes; all-ones is a no-op.
    task automatic test_byte_we();
        txn(1, 1'b0, 30'h7, 32'hAABBCCDD, 4'b0000, "be_full");
        txn(1, 1'b0, 30'h7, 32'h11223344, 4'b1010, "be_part");
        txn(1, 1'b1, 30'h7, 32'h0, 4'b1111, "be_rd");
        checks++;
        if (rd_v[1] !== 32'hAA22CC44) begin
            errors++;
            $display("[TB] FAIL be_const: got %h expected aa22cc44", rd_v[1]);
        end
        txn(1, 1'b0, 30'h7, 32'hFFFFFFFF, 4'b1111, "be_noop");
        txn(1, 1'b1, 30'h7, 32'h0, 4'b0000, "be_rd2");
    endtask
`endif

    // Run every scenario in order, then print the summary.
    initial begin
        for (int d = 0; d < 3; d++) begin
            as_v[d]    = 1'b1;
            rw_v[d]    = 1'b1;
            addr_v[d]  = '0;
            wr_v[d]    = '0;
            last_rd[d] = '0;
`ifdef SPM_BYTE_WE_EN
            be_v[d]    = '1;
`endif
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_reset_mid_wait();
`ifdef SPM_BYTE_WE_EN
        test_byte_we();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
